// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared op encoding, FSM states and iteration count for the
//                HI/LO multiply/divide unit.
//  Revision    : 1.0  initial release
// ============================================================================
package mdu_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_MULT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_step
//  Description : One radix-2 iteration on the {acc, op} working pair:
//                shift-add for multiply, restoring compare-subtract for divide.
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_acc,
    input  logic [XLEN-1:0] i_op,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_acc,
    output logic [XLEN-1:0] o_op
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_rem_s;
    logic [XLEN:0] w_diff;
    logic          w_ge;

    always_comb begin
        // Multiply: op holds the remaining multiplier bits, product low half shifts into op.
        w_sum   = {1'b0, i_acc} + (i_op[0] ? {1'b0, i_b} : '0);
        // Divide: acc is the partial remainder, quotient bits shift into op.
        w_rem_s = {i_acc, i_op[XLEN-1]};
        w_diff  = w_rem_s - {1'b0, i_b};
        w_ge    = (w_rem_s >= {1'b0, i_b});

        if (i_is_div) begin
            o_acc = w_ge ? w_diff[XLEN-1:0] : w_rem_s[XLEN-1:0];
            o_op  = {i_op[XLEN-2:0], w_ge};
        end else begin
            o_acc = w_sum[XLEN:1];
            o_op  = {w_sum[0], i_op[XLEN-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/hilo_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_mdu
//  Description : Iterative multiply/divide engine owning HI/LO, with a stall
//                handshake for HI/LO instructions issued while busy.
//  Revision    : 1.0  initial release
// ============================================================================
module hilo_mdu #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mult,
    input  logic            multu,
    input  logic            div,
    input  logic            divu,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic            mfhi,
    input  logic            mflo,
    input  logic [XLEN-1:0] rs_in,
    input  logic [XLEN-1:0] rt_in,
    output logic [XLEN-1:0] hilo_out,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    import mdu_pkg::*;

    localparam int CNT_W = $clog2(ITER);

    mdu_state_e        r_state;
    mdu_state_e        w_state_nxt;
    mdu_op_e           r_op;
    mdu_op_e           w_start_op;
    logic              w_start;
    logic              w_start_signed;
    logic              w_wr_hi;
    logic              w_wr_lo;
    logic              r_neg_a;
    logic              r_neg_b;
    logic [CNT_W-1:0]  r_count;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [XLEN-1:0]   w_acc_nxt;
    logic [XLEN-1:0]   w_op_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_hi_res;
    logic [XLEN-1:0]   w_lo_res;

    // Strobe priority: div > divu > mult > multu > mthi > mtlo
    always_comb begin
        w_start    = 1'b1;
        w_start_op = OP_MULTU;
        if (div)        w_start_op = OP_DIV;
        else if (divu)  w_start_op = OP_DIVU;
        else if (mult)  w_start_op = OP_MULT;
        else if (multu) w_start_op = OP_MULTU;
        else            w_start    = 1'b0;
    end

    assign w_start_signed = op_is_signed(w_start_op);
    assign w_wr_hi        = mthi & ~w_start;
    assign w_wr_lo        = mtlo & ~w_start & ~mthi;
    assign w_abs_a        = (w_start_signed && rs_in[XLEN-1]) ? -rs_in : rs_in;
    assign w_abs_b        = (w_start_signed && rt_in[XLEN-1]) ? -rt_in : rt_in;

    mdu_step #(.XLEN(XLEN)) u_step (
        .i_is_div (op_is_div(r_op)),
        .i_acc    (r_acc),
        .i_op     (r_opnd),
        .i_b      (r_b),
        .o_acc    (w_acc_nxt),
        .o_op     (w_op_nxt)
    );

    // Sign correction; the neg flags are only ever set for signed ops.
    always_comb begin
        w_prod = {r_acc, r_opnd};
        if (r_neg_a ^ r_neg_b) w_prod = -w_prod;
        w_quo  = (r_neg_a ^ r_neg_b) ? -r_opnd : r_opnd;
        w_rem  = r_neg_a ? -r_acc : r_acc;
        if (op_is_div(r_op)) begin
            // Zero divisor: the remainder path already rebuilds the dividend.
            w_hi_res = w_rem;
            w_lo_res = (r_b == '0) ? '1 : w_quo;
        end else begin
            w_hi_res = w_prod[2*XLEN-1:XLEN];
            w_lo_res = w_prod[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = RUN;
            RUN:     if (r_count == CNT_W'(ITER - 1)) w_state_nxt = FIX;
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= OP_MULTU;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_count <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_op    <= w_start_op;
                        r_neg_a <= w_start_signed & rs_in[XLEN-1];
                        r_neg_b <= w_start_signed & rt_in[XLEN-1];
                        r_count <= '0;
                        r_acc   <= '0;
                        r_opnd  <= op_is_div(w_start_op) ? w_abs_a : w_abs_b;
                        r_b     <= op_is_div(w_start_op) ? w_abs_b : w_abs_a;
                    end else if (w_wr_hi) begin
                        r_hi <= rs_in;
                    end else if (w_wr_lo) begin
                        r_lo <= rs_in;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_opnd  <= w_op_nxt;
                    r_count <= r_count + CNT_W'(1);
                end
                FIX: begin
                    r_hi <= w_hi_res;
                    r_lo <= w_lo_res;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != IDLE);
    assign stall = busy & (mult | multu | div | divu | mthi | mtlo | mfhi | mflo);
    assign hi    = r_hi;
    assign lo    = r_lo;

    always_comb begin
        hilo_out = '0;
        if (!stall) begin
            if (mfhi)      hilo_out = r_hi;
            else if (mflo) hilo_out = r_lo;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_mdu
//  Description : Self-checking bench for hilo_mdu against an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hilo_mdu;

    localparam int K_DIV   = 0;
    localparam int K_DIVU  = 1;
    localparam int K_MULT  = 2;
    localparam int K_MULTU = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mult = 1'b0, multu = 1'b0, div = 1'b0, divu = 1'b0;
    logic        mthi = 1'b0, mtlo = 1'b0, mfhi = 1'b0, mflo = 1'b0;
    logic [31:0] rs_in = '0, rt_in = '0;
    logic [31:0] hilo_out, hi, lo;
    logic        stall, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hilo_mdu #(.XLEN(32), .ITER(32)) dut (
        .clk(clk), .rst(rst),
        .mult(mult), .multu(multu), .div(div), .divu(divu),
        .mthi(mthi), .mtlo(mtlo), .mfhi(mfhi), .mflo(mflo),
        .rs_in(rs_in), .rt_in(rt_in),
        .hilo_out(hilo_out), .stall(stall), .busy(busy),
        .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
    task automatic model(input int kind, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (kind)
            K_MULT: begin
                p = 64'(sa * sb);
                eh = p[63:32]; el = p[31:0];
            end
            K_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                eh = p[63:32]; el = p[31:0];
            end
            K_DIV: begin
                if (b == 0) begin eh = a; el = '1; end
                else begin
                    q = sa / sb; r = sa % sb;
                    p = 64'(q); el = p[31:0];
                    p = 64'(r); eh = p[31:0];
                end
            end
            default: begin
                if (b == 0) begin eh = a; el = '1; end
                else begin el = a / b; eh = a % b; end
            end
        endcase
    endtask

    task automatic clear_strobes();
        {mult, multu, div, divu, mthi, mtlo, mfhi, mflo} = '0;
    endtask

    // 'lower' also raises every lower-priority strobe to exercise arbitration.
    task automatic set_strobe(input int kind, input bit lower);
        div   = (kind == K_DIV);
        divu  = (kind == K_DIVU)  || (lower && kind < K_DIVU);
        mult  = (kind == K_MULT)  || (lower && kind < K_MULT);
        multu = (kind == K_MULTU) || (lower && kind < K_MULTU);
        mthi  = lower;
        mtlo  = lower;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_op(input string tag, input int kind, input logic [31:0] a,
                          input logic [31:0] b, input bit lower);
        logic [31:0] eh, el;
        int cyc;
        model(kind, a, b, eh, el);
        rs_in = a; rt_in = b;
        set_strobe(kind, lower);
        @(posedge clk); #1;
        clear_strobes();
        wait_idle(cyc);
        check({tag, ".busy_cycles"}, 64'(cyc), 64'd33);
        check({tag, ".hi"}, {32'd0, hi}, {32'd0, eh});
        check({tag, ".lo"}, {32'd0, lo}, {32'd0, el});
        mflo = 1'b1; #1;
        check({tag, ".mflo"}, {32'd0, hilo_out}, {32'd0, el});
        mflo = 1'b0; mfhi = 1'b1; #1;
        check({tag, ".mfhi"}, {32'd0, hilo_out}, {32'd0, eh});
        mfhi = 1'b0;
    endtask

    initial begin
        logic [31:0] eh, el, a, b;
        int cyc, stalls, kind;

        repeat (2) @(posedge clk);
        #1;
        check("rst.busy",  64'(busy),  64'd0);
        check("rst.stall", 64'(stall), 64'd0);
        check("rst.hi",    {32'd0, hi}, 64'd0);
        check("rst.lo",    {32'd0, lo}, 64'd0);
        rst = 1'b0;

        run_op("multu_max", K_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_neg",  K_MULT,  32'hFFFF_FFFD, 32'd7, 1'b0);
        run_op("div_neg",   K_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu",      K_DIVU,  32'd100, 32'd7, 1'b0);
        run_op("divu_zero", K_DIVU,  32'h0000_1234, 32'd0, 1'b0);
        run_op("div_zero",  K_DIV,   32'hFFFF_FF00, 32'd0, 1'b0);
        run_op("div_ovf",   K_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("prio_div",  K_DIV,   32'd1000, 32'hFFFF_FFFD, 1'b1);
        run_op("prio_mult", K_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 1'b1);

        // mflo during busy: stalled until the engine drains, then sees new LO
        model(K_MULT, 32'd12345, 32'hFFFF_0001, eh, el);
        rs_in = 32'd12345; rt_in = 32'hFFFF_0001; mult = 1'b1;
        @(posedge clk); #1;
        mult = 1'b0; mflo = 1'b1; #1;
        stalls = 0; cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (stall && hilo_out == 0) stalls++;
            @(posedge clk); #1;
        end
        check("mflo_stall.cycles", 64'(stalls), 64'd33);
        check("mflo_stall.stall",  64'(stall), 64'd0);
        check("mflo_stall.data",   {32'd0, hilo_out}, {32'd0, el});
        mflo = 1'b0;

        // Second mult presented while busy is held off until IDLE
        model(K_MULTU, 32'd3, 32'd5, eh, el);
        rs_in = 32'd3; rt_in = 32'd5; multu = 1'b1;
        @(posedge clk); #1;
        rs_in = 32'd9; rt_in = 32'd11; multu = 1'b1; #1;
        check("hold.stall", 64'(stall), 64'd1);
        wait_idle(cyc);
        check("hold.first_lo", {32'd0, lo}, {32'd0, el});
        check("hold.stall_off", 64'(stall), 64'd0);
        @(posedge clk); #1;
        multu = 1'b0;
        check("hold.accepted", 64'(busy), 64'd1);
        wait_idle(cyc);
        check("hold.second_lo", {32'd0, lo}, 64'd99);

        // Reset in the middle of RUN aborts and clears HI/LO
        rs_in = 32'd77; rt_in = 32'd5; divu = 1'b1;
        @(posedge clk); #1;
        divu = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.hi",   {32'd0, hi}, 64'd0);
        check("midrst.lo",   {32'd0, lo}, 64'd0);
        @(posedge clk); #1;
        check("midrst.idle", 64'(busy), 64'd0);

        // mthi / mtlo writes and reads
        rs_in = 32'hA5A5_A5A5; mthi = 1'b1; #1;
        check("mthi.stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        mthi = 1'b0; mfhi = 1'b1; #1;
        check("mfhi.data",  {32'd0, hilo_out}, 64'h0000_0000_A5A5_A5A5);
        check("mfhi.stall", 64'(stall), 64'd0);
        mfhi = 1'b0;
        rs_in = 32'h1357_9BDF; mtlo = 1'b1;
        @(posedge clk); #1;
        mtlo = 1'b0;
        check("mtlo.lo", {32'd0, lo}, 64'h0000_0000_1357_9BDF);
        check("mtlo.hi_kept", {32'd0, hi}, 64'h0000_0000_A5A5_A5A5);

        // Randomized ops against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 9);
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            run_op("rand", kind, a, b, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hilo_mdu.md
Name: hilo_mdu

Overview:
- Multi-cycle multiply/divide responder that owns the HI/LO register pair.
- Serves the CPU's mult/multu/div/divu/mthi/mtlo/mfhi/mflo strobes.
- Replaces the combinational MULT/DIV cores and the free-running HI/LO registers with an iterative radix-2 engine.
- Provides a stall handshake back to the CPU pipeline; sits between cpu55 and the CP0/HI/LO read mux at the CPU top level.

Parameters:
- XLEN, 32, operand/HI/LO width.
- ITER, 32, number of iteration cycles (equals XLEN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- mult  in  1  signed multiply strobe.
- multu  in  1  unsigned multiply strobe.
- div  in  1  signed divide strobe.
- divu  in  1  unsigned divide strobe.
- mthi  in  1  write rs_in to HI.
- mtlo  in  1  write rs_in to LO.
- mfhi  in  1  read HI.
- mflo  in  1  read LO.
- rs_in  in  XLEN  rs operand (multiplicand/dividend, mthi/mtlo data).
- rt_in  in  XLEN  rt operand (multiplier/divisor).
- hilo_out  out  XLEN  mfhi→HI, mflo→LO, else 0 (combinational).
- stall  out  1  CPU must hold the current instruction.
- busy  out  1  engine not IDLE.
- hi  out  XLEN  HI register (diagnostic).
- lo  out  XLEN  LO register (diagnostic).

Behaviour:
- Reset: the single clock is clk; reset is rst, synchronous, active-high. HI=0, LO=0, state=IDLE, busy=0, stall=0, counter=0.
- Reset mid-operation aborts the operation, clears HI/LO and returns to IDLE on that edge.
- FSM states are IDLE, RUN and FIX.
- IDLE:
  - At most one strobe is valid per cycle. If several are high, priority is div > divu > mult > multu > mthi > mtlo, and the rest are ignored.
  - On a md-op strobe: latch |rs|, |rt| and the sign flags (signed ops only), plus the op. Counter=0, go to RUN.
  - mthi/mtlo: write HI/LO from rs_in on that edge and stay in IDLE.
- RUN:
  - One shift-add (multiply) or one restoring shift-subtract (divide) step per cycle; counter increments.
  - After ITER steps (counter==ITER-1 at the edge), go to FIX.
- FIX:
  - Apply sign correction and write HI/LO on the FIX edge, then go to IDLE.
  - Signed multiply: negate the 64-bit product if signs differ.
  - Signed divide: quotient is negated if signs differ; remainder takes the sign of the dividend.
- Latency: accept edge E0; RUN covers edges E1..E32; HI/LO updated at E33. busy=1 from after E0 through the E33 edge.
- Results:
  - Multiply: HI=product[63:32], LO=product[31:0].
  - Divide: LO=quotient, HI=remainder.
- Divide by zero (rt=0), both div and divu: LO=32'hFFFFFFFF, HI=rs_in as latched. Still takes full latency.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- stall = busy & (mult|multu|div|divu|mthi|mtlo|mfhi|mflo). The CPU holds the instruction, so the strobe is re-presented and accepted/served in the cycle after busy falls.
- hilo_out when not stalled: mfhi→HI, mflo→LO, else 0.
- Reads in the first IDLE cycle after FIX see the new result.
- Non-HI/LO instructions during busy are not stalled.

Decomposition:
- Shared package mdu_pkg holds:
  - op encoding: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state enum: IDLE, RUN, FIX;
  - ITER constant.
- One sub-module, mdu_step: combinational single iteration (add-shift or compare-subtract-shift) on the {acc, op} 64-bit working pair.
- Top holds the FSM, counter, sign handling and HI/LO.

Test Plan:
- multu rs=0xFFFFFFFF rt=0xFFFFFFFF → after 34 edges HI=0xFFFFFFFE, LO=0x00000001; busy high exactly 33 cycles.
- mult rs=0xFFFFFFFD(-3) rt=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- div rs=0xFFFFFFF9(-7) rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu rs=100 rt=7 → LO=14, HI=2.
- divu rt=0 rs=0x1234 → LO=0xFFFFFFFF, HI=0x1234.
- div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- mflo asserted one cycle after mult issue:
  - stall=1 until busy falls;
  - then hilo_out = new LO with stall=0;
  - a second mult issued during busy is accepted only after IDLE.
- rst pulsed at RUN counter=10 → next cycle busy=0, HI=LO=0.
- mthi 0xA5A5A5A5 then mfhi → hilo_out=0xA5A5A5A5, no stall.
